snitch_tcdm_bank_rw_arbiter: RTL and testbench

Per-bank arbiter that merges the memory-side request streams of the write-path and read-path TCDM interconnects onto one shared set of NumOut SRAM bank ports. Per bank, it grants one side per cycle: write-priority with a bounded read-starvation override. It steers the fixed-latency bank response data back to the side that issued the accepted request. It sits between the two split interconnect instances and the TCDM banks.

---
 rtl/snitch_tcdm_split_pkg.sv | 49 ++++
 rtl/snitch_tcdm_bank_rw_arb_lane.sv | 119 +++++++++++
 rtl/snitch_tcdm_bank_rw_arbiter.sv | 57 +++++
 tb/tb_snitch_tcdm_bank_rw_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snitch_tcdm_split_pkg.sv
//==============================================================================
// Module : snitch_tcdm_split_pkg
// Brief  : Shared types and defaults for the split read/write TCDM bank arbiter.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package snitch_tcdm_split_pkg;

    localparam int unsigned NumOut                = 8;
    localparam int unsigned MemoryResponseLatency = 1;
    localparam int unsigned MaxRdStall            = 4;

    typedef enum logic {
        SrcWr = 1'b0,
        SrcRd = 1'b1
    } src_e;

    typedef struct packed {
        logic vld;
        src_e src;
    } rsp_entry_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [3:0]  amo;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [0:0]  user;
    } mem_req_chan_t;

    typedef struct packed {
        logic          q_valid;
        mem_req_chan_t q;
    } mem_req_t;

    typedef struct packed {
        logic [63:0] data;
    } mem_rsp_chan_t;

    typedef struct packed {
        logic          q_ready;
        mem_rsp_chan_t p;
    } mem_rsp_t;

endpackage

`default_nettype wire

// File: rtl/snitch_tcdm_bank_rw_arb_lane.sv
//==============================================================================
// Module : snitch_tcdm_bank_rw_arb_lane
// Brief  : One bank lane: write-priority grant with bounded read starvation,
//          fixed-latency response steering. Optional SNAX_TCDM_ARB_PERF_CNT_EN.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module snitch_tcdm_bank_rw_arb_lane #(
    parameter int unsigned MemoryResponseLatency = snitch_tcdm_split_pkg::MemoryResponseLatency,
    parameter int unsigned MaxRdStall            = snitch_tcdm_split_pkg::MaxRdStall,
    parameter type         mem_req_t             = snitch_tcdm_split_pkg::mem_req_t,
    parameter type         mem_rsp_t             = snitch_tcdm_split_pkg::mem_rsp_t
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  mem_req_t    wr_req_i,
    output mem_rsp_t    wr_rsp_o,
    input  mem_req_t    rd_req_i,
    output mem_rsp_t    rd_rsp_o,
    output mem_req_t    mem_req_o,
    input  mem_rsp_t    mem_rsp_i
`ifdef SNAX_TCDM_ARB_PERF_CNT_EN
    ,
    input  logic        perf_clr_i,
    output logic [31:0] perf_conflict_o
`endif
);
    import snitch_tcdm_split_pkg::*;

    localparam int unsigned     StallW   = $clog2(MaxRdStall + 1);
    localparam logic [StallW-1:0] StallMax = StallW'(MaxRdStall);

    logic                                    wr_v, rd_v, bank_rdy;
    logic                                    grant_rd, accepted;
    logic [StallW-1:0]                       stall_q, stall_d;
    rsp_entry_t [MemoryResponseLatency-1:0]  pipe_q, pipe_d;
    rsp_entry_t                              exit_e;

    assign wr_v     = wr_req_i.q_valid;
    assign rd_v     = rd_req_i.q_valid;
    assign bank_rdy = mem_rsp_i.q_ready;

    // Read only wins a conflict once it has lost MaxRdStall accepted writes in a row.
    assign grant_rd  = rd_v & (~wr_v | (stall_q == StallMax));
    assign accepted  = (grant_rd ? rd_v : wr_v) & bank_rdy;
    assign mem_req_o = grant_rd ? rd_req_i : wr_req_i;
    assign exit_e    = pipe_q[MemoryResponseLatency-1];

    always_comb begin
        wr_rsp_o         = '0;
        rd_rsp_o         = '0;
        wr_rsp_o.q_ready = ~grant_rd & bank_rdy;
        rd_rsp_o.q_ready = grant_rd & bank_rdy;
        if (exit_e.vld) begin
            if (exit_e.src == SrcRd) begin
                rd_rsp_o.p.data = mem_rsp_i.p.data;
            end else begin
                wr_rsp_o.p.data = mem_rsp_i.p.data;
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!rd_v || (grant_rd && accepted)) begin
            stall_d = '0;
        end else if (accepted && (stall_q < StallMax)) begin
            stall_d = stall_q + StallW'(1);
        end
    end

    always_comb begin
        pipe_d[0].vld = accepted;
        pipe_d[0].src = SrcWr;
        if (grant_rd) begin
            pipe_d[0].src = SrcRd;
        end
        for (int i = 1; i < int'(MemoryResponseLatency); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
            pipe_q  <= '0;
        end else begin
            stall_q <= stall_d;
            pipe_q  <= pipe_d;
        end
    end

`ifdef SNAX_TCDM_ARB_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (perf_clr_i) begin
            perf_d = '0;
        end else if (wr_v && rd_v && (perf_q != '1)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_conflict_o = perf_q;
`endif

endmodule

`default_nettype wire

// File: rtl/snitch_tcdm_bank_rw_arbiter.sv
//==============================================================================
// Module : snitch_tcdm_bank_rw_arbiter
// Brief  : Merges write-path and read-path TCDM bank requests onto NumOut banks.
//          Optional conflict counters via SNAX_TCDM_ARB_PERF_CNT_EN.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module snitch_tcdm_bank_rw_arbiter #(
    parameter int unsigned NumOut                = snitch_tcdm_split_pkg::NumOut,
    parameter int unsigned MemoryResponseLatency = snitch_tcdm_split_pkg::MemoryResponseLatency,
    parameter int unsigned MaxRdStall            = snitch_tcdm_split_pkg::MaxRdStall,
    parameter type         mem_req_t             = snitch_tcdm_split_pkg::mem_req_t,
    parameter type         mem_rsp_t             = snitch_tcdm_split_pkg::mem_rsp_t
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  mem_req_t [NumOut-1:0]   wr_mem_req_i,
    output mem_rsp_t [NumOut-1:0]   wr_mem_rsp_o,
    input  mem_req_t [NumOut-1:0]   rd_mem_req_i,
    output mem_rsp_t [NumOut-1:0]   rd_mem_rsp_o,
    output mem_req_t [NumOut-1:0]   mem_req_o,
    input  mem_rsp_t [NumOut-1:0]   mem_rsp_i
`ifdef SNAX_TCDM_ARB_PERF_CNT_EN
    ,
    input  logic                    perf_clr_i,
    output logic [NumOut-1:0][31:0] perf_conflict_o
`endif
);
    import snitch_tcdm_split_pkg::*;

    for (genvar i = 0; i < NumOut; i++) begin : g_lane
        snitch_tcdm_bank_rw_arb_lane #(
            .MemoryResponseLatency (MemoryResponseLatency),
            .MaxRdStall            (MaxRdStall),
            .mem_req_t             (mem_req_t),
            .mem_rsp_t             (mem_rsp_t)
        ) u_lane (
            .clk_i           (clk_i),
            .rst_ni          (rst_ni),
            .wr_req_i        (wr_mem_req_i[i]),
            .wr_rsp_o        (wr_mem_rsp_o[i]),
            .rd_req_i        (rd_mem_req_i[i]),
            .rd_rsp_o        (rd_mem_rsp_o[i]),
            .mem_req_o       (mem_req_o[i]),
            .mem_rsp_i       (mem_rsp_i[i])
`ifdef SNAX_TCDM_ARB_PERF_CNT_EN
            ,
            .perf_clr_i      (perf_clr_i),
            .perf_conflict_o (perf_conflict_o[i])
`endif
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_snitch_tcdm_bank_rw_arbiter.sv
//==============================================================================
// Module : tb_snitch_tcdm_bank_rw_arbiter
// Brief  : Self-checking bench; two arbiter instances (latency 1 and 2) share
//          stimulus. Optional SNAX_TCDM_ARB_PERF_CNT_EN section.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_snitch_tcdm_bank_rw_arbiter;
    import snitch_tcdm_split_pkg::*;

    localparam int N         = 8;
    localparam int MAX_STALL = 4;

    logic clk_i = 1'b0;
    logic rst_ni;

    mem_req_t [N-1:0] wr_req, rd_req, req_a, req_b;
    mem_rsp_t [N-1:0] wr_rsp_a, rd_rsp_a, wr_rsp_b, rd_rsp_b, bank_rsp;
`ifdef SNAX_TCDM_ARB_PERF_CNT_EN
    logic             perf_clr;
    logic [N-1:0][31:0] perf_a, perf_b;
`endif

    always #5 clk_i = ~clk_i;

    snitch_tcdm_bank_rw_arbiter #(
        .NumOut(N), .MemoryResponseLatency(1), .MaxRdStall(MAX_STALL)
    ) dut_a (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .wr_mem_req_i(wr_req), .wr_mem_rsp_o(wr_rsp_a),
        .rd_mem_req_i(rd_req), .rd_mem_rsp_o(rd_rsp_a),
        .mem_req_o(req_a), .mem_rsp_i(bank_rsp)
`ifdef SNAX_TCDM_ARB_PERF_CNT_EN
        , .perf_clr_i(perf_clr), .perf_conflict_o(perf_a)
`endif
    );

    snitch_tcdm_bank_rw_arbiter #(
        .NumOut(N), .MemoryResponseLatency(2), .MaxRdStall(MAX_STALL)
    ) dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .wr_mem_req_i(wr_req), .wr_mem_rsp_o(wr_rsp_b),
        .rd_mem_req_i(rd_req), .rd_mem_rsp_o(rd_rsp_b),
        .mem_req_o(req_b), .mem_rsp_i(bank_rsp)
`ifdef SNAX_TCDM_ARB_PERF_CNT_EN
        , .perf_clr_i(perf_clr), .perf_conflict_o(perf_b)
`endif
    );

    // Reference model: per-cycle history of what each bank accepted and for whom.
    typedef struct packed {
        logic [N-1:0] acc;
        logic [N-1:0] rd;
    } hist_t;

    hist_t hist[$];
    int    lost_streak [N];
    int    n_pass  = 0;
    int    n_total = 0;

    typedef struct {
        bit wv;
        bit rv;
        bit rdy;
        bit exp_rd;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic bit read_wins(input int l);
        if (!rd_req[l].q_valid) return 1'b0;
        if (!wr_req[l].q_valid) return 1'b1;
        return lost_streak[l] >= MAX_STALL;
    endfunction

    function automatic logic [63:0] exp_data(input int l, input int lat, input bit want_rd);
        hist_t h;
        if (!rst_ni || hist.size() < lat) return '0;
        h = hist[hist.size() - lat];
        if (h.acc[l] && (h.rd[l] == want_rd)) return bank_rsp[l].p.data;
        return '0;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int l = 0; l < N; l++) lost_streak[l] = 0;
    endtask

    task automatic check_model();
        bit       g, rdy;
        mem_req_t er;
        for (int l = 0; l < N; l++) begin
            g   = read_wins(l);
            rdy = bank_rsp[l].q_ready;
            er  = g ? rd_req[l] : wr_req[l];
            check($sformatf("lane%0d_lat1", l),
                  {req_a[l], wr_rsp_a[l].q_ready, rd_rsp_a[l].q_ready, wr_rsp_a[l].p.data, rd_rsp_a[l].p.data},
                  {er, !g && rdy, g && rdy, exp_data(l, 1, 1'b0), exp_data(l, 1, 1'b1)});
            check($sformatf("lane%0d_lat2", l),
                  {req_b[l], wr_rsp_b[l].q_ready, rd_rsp_b[l].q_ready, wr_rsp_b[l].p.data, rd_rsp_b[l].p.data},
                  {er, !g && rdy, g && rdy, exp_data(l, 2, 1'b0), exp_data(l, 2, 1'b1)});
        end
    endtask

    task automatic model_update();
        hist_t h;
        bit    g, acc;
        if (!rst_ni) begin
            model_reset();
            return;
        end
        h = '0;
        for (int l = 0; l < N; l++) begin
            g   = read_wins(l);
            acc = (g ? rd_req[l].q_valid : wr_req[l].q_valid) && bank_rsp[l].q_ready;
            h.acc[l] = acc;
            h.rd[l]  = g;
            if (!rd_req[l].q_valid || (acc && g)) lost_streak[l] = 0;
            else if (acc) lost_streak[l] = (lost_streak[l] < MAX_STALL) ? lost_streak[l] + 1 : MAX_STALL;
        end
        hist.push_back(h);
        if (hist.size() > 4) void'(hist.pop_front());
    endtask

    function automatic mem_req_t mk_req(input logic v, input logic [31:0] a, input logic w, input logic [63:0] d);
        mem_req_t r;
        r         = '0;
        r.q_valid = v;
        r.q.addr  = a;
        r.q.write = w;
        r.q.data  = d;
        r.q.strb  = '1;
        return r;
    endfunction

    task automatic idle();
        wr_req = '0;
        rd_req = '0;
        for (int l = 0; l < N; l++) bank_rsp[l].q_ready = 1'b1;
    endtask

    task automatic settle();
        #4;
        check_model();
    endtask

    task automatic advance();
        @(posedge clk_i);
        model_update();
        @(negedge clk_i);
        for (int l = 0; l < N; l++) bank_rsp[l].p.data = {$urandom, $urandom};
    endtask

    initial begin
        rst_ni   = 1'b0;
        bank_rsp = '0;
        idle();
`ifdef SNAX_TCDM_ARB_PERF_CNT_EN
        perf_clr = 1'b0;
`endif
        // Lane-1 grant table: {wr valid, rd valid, bank ready, expect read grant}
        tbl.push_back('{1,1,1,0}); tbl.push_back('{1,1,1,0}); tbl.push_back('{1,1,1,0});
        tbl.push_back('{1,1,1,0}); tbl.push_back('{1,1,1,1}); tbl.push_back('{1,1,1,0});
        tbl.push_back('{1,1,1,0}); tbl.push_back('{1,1,1,0}); tbl.push_back('{1,1,1,0});
        tbl.push_back('{1,1,1,1});
        tbl.push_back('{1,1,1,0}); tbl.push_back('{1,1,1,0}); tbl.push_back('{1,1,1,0});
        tbl.push_back('{1,1,1,0}); tbl.push_back('{1,1,0,1}); tbl.push_back('{1,1,0,1});
        tbl.push_back('{1,1,0,1}); tbl.push_back('{1,1,1,1});
        tbl.push_back('{1,1,1,0}); tbl.push_back('{1,1,1,0}); tbl.push_back('{1,0,1,0});
        tbl.push_back('{1,1,1,0}); tbl.push_back('{1,1,1,0}); tbl.push_back('{1,1,1,0});
        tbl.push_back('{1,1,1,0}); tbl.push_back('{1,1,1,1}); tbl.push_back('{0,1,1,1});
        tbl.push_back('{0,0,1,0}); tbl.push_back('{1,0,0,0});
        tbl.push_back('{1,1,1,0}); tbl.push_back('{1,1,0,0}); tbl.push_back('{1,1,1,0});
        tbl.push_back('{1,1,1,0}); tbl.push_back('{1,1,1,0}); tbl.push_back('{1,1,1,1});

        model_reset();
        @(negedge clk_i);
        bank_rsp[0].p.data = 64'h1111_2222_3333_4444;
        settle();
        check("reset_rd_data", {rd_rsp_a[0].p.data, rd_rsp_b[0].p.data}, '0);
        advance();
        settle();
        advance();
        rst_ni = 1'b1;

        // Write only on lane 0, three consecutive accepted cycles.
        for (int c = 0; c < 3; c++) begin
            idle();
            wr_req[0] = mk_req(1'b1, 32'h10, 1'b1, 64'(c + 5));
            settle();
            check("wr_only_req", {req_a[0].q_valid, req_a[0].q.addr, wr_rsp_a[0].q_ready},
                  {1'b1, 32'h10, 1'b1});
            check("wr_only_rd_data", {rd_rsp_a[0].p.data, rd_rsp_b[0].p.data}, '0);
            advance();
        end
        idle();
        settle();
        advance();

        // Read only on lane 3; data returns one cycle after accept.
        rd_req[3] = mk_req(1'b1, 32'h40, 1'b0, '0);
        settle();
        advance();
        idle();
        bank_rsp[3].p.data = 64'hDEAD_BEEF_0000_0001;
        settle();
        check("rd_lat1_data", rd_rsp_a[3].p.data, 64'hDEAD_BEEF_0000_0001);
        check("rd_lat1_wr_data", wr_rsp_a[3].p.data, '0);
        advance();
        settle();
        advance();

        // Table-driven grant sequence on lane 1.
        foreach (tbl[i]) begin
            idle();
            wr_req[1] = mk_req(tbl[i].wv, 32'h100, 1'b1, {$urandom, $urandom});
            rd_req[1] = mk_req(tbl[i].rv, 32'h200, 1'b0, '0);
            bank_rsp[1].q_ready = tbl[i].rdy;
            settle();
            check($sformatf("tbl%0d_grant", i),
                  {req_a[1].q_valid, req_a[1].q.addr, wr_rsp_a[1].q_ready, rd_rsp_a[1].q_ready},
                  {tbl[i].wv | tbl[i].rv, tbl[i].exp_rd ? 32'h200 : 32'h100,
                   !tbl[i].exp_rd && tbl[i].rdy, tbl[i].exp_rd && tbl[i].rdy});
            advance();
        end

        // Randomized traffic on all lanes.
        for (int c = 0; c < 400; c++) begin
            for (int l = 0; l < N; l++) begin
                wr_req[l] = mk_req($urandom_range(0, 9) < 7, $urandom, 1'($urandom_range(0, 1)), {$urandom, $urandom});
                rd_req[l] = mk_req($urandom_range(0, 9) < 5, $urandom, 1'b0, '0);
                bank_rsp[l].q_ready = $urandom_range(0, 9) < 8;
            end
            settle();
            advance();
        end

        // Reset with a read in flight on the latency-2 instance.
        idle();
        settle();
        advance();
        for (int c = 0; c < 3; c++) begin
            idle();
            wr_req[1] = mk_req(1'b1, 32'h100, 1'b1, '0);
            rd_req[1] = mk_req(1'b1, 32'h200, 1'b0, '0);
            if (c == 2) rd_req[0] = mk_req(1'b1, 32'h80, 1'b0, '0);
            settle();
            advance();
        end
        idle();
        rst_ni = 1'b0;
        model_reset();
        bank_rsp[0].p.data = 64'h0BAD_0BAD_0BAD_0BAD;
        settle();
        check("rst_mid_rd_data", rd_rsp_b[0].p.data, '0);
        advance();
        rst_ni = 1'b1;
        for (int c = 0; c < 2; c++) begin
            bank_rsp[0].p.data = 64'h0BAD_0BAD_0BAD_0BAD;
            settle();
            check("post_rst_rd_data", rd_rsp_b[0].p.data, '0);
            advance();
        end
        for (int c = 0; c < 5; c++) begin
            idle();
            wr_req[1] = mk_req(1'b1, 32'h100, 1'b1, '0);
            rd_req[1] = mk_req(1'b1, 32'h200, 1'b0, '0);
            settle();
            check("post_rst_stall", req_a[1].q.addr, (c == 4) ? 32'h200 : 32'h100);
            advance();
        end

`ifdef SNAX_TCDM_ARB_PERF_CNT_EN
        idle();
        settle();
        check("perf_after_reset", perf_a[2], 32'd0);
        perf_clr = 1'b1;
        advance();
        perf_clr = 1'b0;
        for (int c = 0; c < 10; c++) begin
            idle();
            wr_req[2] = mk_req(1'b1, 32'h300, 1'b1, '0);
            rd_req[2] = mk_req(1'b1, 32'h400, 1'b0, '0);
            settle();
            advance();
        end
        idle();
        settle();
        check("perf_count10", {perf_a[2], perf_b[2]}, {32'd10, 32'd10});
        check("perf_other_lane", perf_a[3], 32'd0);
        wr_req[2] = mk_req(1'b1, 32'h300, 1'b1, '0);
        rd_req[2] = mk_req(1'b1, 32'h400, 1'b0, '0);
        perf_clr  = 1'b1;
        settle();
        advance();
        perf_clr = 1'b0;
        idle();
        settle();
        check("perf_clear", perf_a[2], 32'd0);
        advance();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
